// File: rtl/aes_dec_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_dec_round_ctrl_if
// Groups the handshake and datapath-control signals of the AES decryption
// round sequencer.
//   master : the sequencer (drives in_ready, sel, round_idx, dp_en,
//            inv_mix_en, busy, out_valid; receives key_valid, start, out_ready)
//   slave  : the surrounding source/sink/datapath (opposite directions)
// ---------------------------------------------------------------------------
interface aes_dec_round_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             key_valid;
  logic             start;
  logic             in_ready;
  logic             sel;
  logic [IDX_W-1:0] round_idx;
  logic             dp_en;
  logic             inv_mix_en;
  logic             busy;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  key_valid, start, out_ready,
    output in_ready, sel, round_idx, dp_en, inv_mix_en, busy, out_valid
  );

  modport slave (
    output key_valid, start, out_ready,
    input  in_ready, sel, round_idx, dp_en, inv_mix_en, busy, out_valid
  );
endinterface

// File: rtl/aes_dec_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_dec_round_ctrl
// Round sequencer for an AES inverse-cipher datapath. For each accepted
// ciphertext it issues AddRoundKey(NR), NR-1 full inverse rounds (with
// InvMixColumns) using keys NR-1..1, and a final inverse round with key 0,
// then presents the plaintext with a valid/ready handshake.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bus (master)   : key_valid/start/in_ready toward the ciphertext source,
//                    out_valid/out_ready toward the plaintext sink,
//                    sel/round_idx/dp_en/inv_mix_en/busy toward the datapath
// Parameters:
//   NR    : number of AES rounds (10, 12 or 14)
//   IDX_W : round-key index width, 2**IDX_W > NR
// ---------------------------------------------------------------------------
module aes_dec_round_ctrl #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_dec_round_ctrl_if.master   bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_dec_round_ctrl: NR must be 10, 12 or 14");
  end
  if ((2 ** IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_dec_round_ctrl: IDX_W too narrow for NR");
  end

  localparam logic [IDX_W-1:0] NR_IDX  = IDX_W'(NR);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic             in_ready_c;
  logic             sel_c;
  logic [IDX_W-1:0] round_idx_c;
  logic             dp_en_c;
  logic             inv_mix_en_c;
  logic             busy_c;
  logic             out_valid_c;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new block is taken from IDLE, or straight out of DONE when the
  // current plaintext is being handed off in the same cycle.
  assign in_ready_c = bus.key_valid &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
  assign accept     = in_ready_c && bus.start;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_c        = 1'b0;
    round_idx_c  = '0;
    dp_en_c      = 1'b0;
    inv_mix_en_c = 1'b0;
    busy_c       = 1'b0;
    out_valid_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_INIT;
          cnt_d   = NR_IDX;
        end
      end

      S_INIT: begin
        dp_en_c     = 1'b1;
        round_idx_c = NR_IDX;
        busy_c      = 1'b1;
        state_d     = S_ROUND;
        cnt_d       = NR_IDX - IDX_ONE;
      end

      S_ROUND: begin
        sel_c        = 1'b1;
        dp_en_c      = 1'b1;
        inv_mix_en_c = 1'b1;
        round_idx_c  = cnt_q;
        busy_c       = 1'b1;
        // Round 1 is the last full round; key 0 belongs to FINAL, so the
        // counter stops here instead of wrapping.
        if (cnt_q == IDX_ONE) begin
          state_d = S_FINAL;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - IDX_ONE;
        end
      end

      S_FINAL: begin
        sel_c   = 1'b1;
        dp_en_c = 1'b1;
        busy_c  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        // sel stays at feedback and dp_en low so the round register
        // holds the plaintext steady under backpressure.
        sel_c       = 1'b1;
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          if (accept) begin
            state_d = S_INIT;
            cnt_d   = NR_IDX;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.sel        = sel_c;
  assign bus.round_idx  = round_idx_c;
  assign bus.dp_en      = dp_en_c;
  assign bus.inv_mix_en = inv_mix_en_c;
  assign bus.busy       = busy_c;
  assign bus.out_valid  = out_valid_c;

endmodule

// File: doc/aes_dec_round_ctrl.md
# aes_dec_round_ctrl

Round sequencer for the AES decryption datapath. It runs the inverse cipher: AddRoundKey(NR), then NR-1 inverse rounds with InvMixColumns, then a final inverse round without InvMixColumns. It drives the datapath input-mux select, the round-key index (descending NR→0), and the stage enables. It wraps the sequence in a valid/ready handshake toward the ciphertext source and the plaintext sink.

## Interface
- NR, default 10: number of AES rounds; legal values are 10, 12 and 14.
- IDX_W, default 4: width of the round-key index; must satisfy 2^IDX_W > NR.

- clk  input  1: single clock; all state changes on the rising edge.
- rst  input  1: synchronous, active-high reset.
- key_valid  input  1: round-key schedule is complete and stable; start is accepted only while this is high.
- start  input  1: ciphertext present on the datapath input; sampled only when in_ready=1.
- in_ready  output  1: the block can accept start this cycle.
- sel  output  1: datapath mux select; 0 = load ciphertext, 1 = feedback of the round register.
- round_idx  output  IDX_W: round-key address into the key schedule.
- dp_en  output  1: datapath round register load enable.
- inv_mix_en  output  1: InvMixColumns stage active; when low, that stage is bypassed.
- busy  output  1: a block is in flight (any state other than IDLE).
- out_valid  output  1: plaintext valid on the datapath output.
- out_ready  input  1: sink accepts plaintext.

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE. An internal counter cnt is IDX_W bits wide.
- All outputs are a Moore decode of state and cnt. Exception: in_ready also depends on key_valid and out_ready.
- IDLE
  - Outputs: sel=0, dp_en=0, inv_mix_en=0, busy=0, out_valid=0, round_idx=0.
  - Transition: start && key_valid → INIT, cnt←NR.
- INIT
  - Outputs: sel=0, dp_en=1, inv_mix_en=0, round_idx=NR, busy=1.
  - Action: the ciphertext is XORed with key NR.
  - Transition: next cycle → ROUND, cnt←NR-1.
- ROUND
  - Outputs: sel=1, dp_en=1, inv_mix_en=1, round_idx=cnt, busy=1.
  - Action: InvShiftRows, InvSubBytes, AddRoundKey(cnt), InvMixColumns.
  - Transition: if cnt==1 → FINAL with cnt←0; otherwise cnt←cnt-1.
- FINAL
  - Outputs: sel=1, dp_en=1, inv_mix_en=0, round_idx=0, busy=1.
  - Transition: next cycle → DONE.
- DONE
  - Outputs: out_valid=1, dp_en=0, sel=1, round_idx=0, busy=1.
  - Transfer occurs when out_valid && out_ready.
  - On transfer with start && key_valid → INIT (back-to-back), cnt←NR.
  - On transfer otherwise → IDLE.
  - Without transfer: hold DONE, with outputs and datapath contents stable.
- in_ready = key_valid && (state==IDLE || (state==DONE && out_ready)).
- start while busy, outside the DONE-transfer case, is ignored; it is not queued.
- key_valid dropping mid-sequence does not abort; the sequence completes. key_valid stability is the key-schedule owner's responsibility.
- cnt never wraps: it is decremented only in ROUND while cnt≥2.
- If NR is outside {10, 12, 14}, elaboration fails via a generate-time check.

## Timing
- Reset: rst sampled high → the next state is IDLE with cnt=0.
  - Outputs after that edge: sel=0, round_idx=0, dp_en=0, inv_mix_en=0, busy=0, out_valid=0.
  - in_ready=key_valid.
- rst overrides every state, including mid-ROUND and DONE with out_valid high. The in-flight block is dropped and no out_valid pulse follows.
- Sequence, with cycle 0 being the cycle start is accepted:
  - Cycle 1: INIT.
  - Cycles 2..NR: ROUND, round_idx = NR-1 down to 1.
  - Cycle NR+1: FINAL.
  - Cycle NR+2: DONE, out_valid=1.
- Latency from start to out_valid is NR+2 cycles: 12 / 14 / 16 for NR = 10 / 12 / 14.
- dp_en is high for exactly NR+1 consecutive cycles per block.
- Throughput with out_ready tied high: one block every NR+2 cycles. The DONE→INIT back-to-back path avoids an IDLE bubble.

## Test plan
- Reset then single block, NR=10, out_ready=1, start pulsed at cycle 0:
  - round_idx sequence 10,9,8,…,1,0 on cycles 1..11.
  - sel=0 only on cycle 1; inv_mix_en=1 on cycles 2..10 only.
  - out_valid=1 on cycle 12 for one cycle; then IDLE, busy=0.
  - Datapath with FIPS-197 C.1 key 000102…0f: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises.
  - out_valid and round_idx=0 are held for 6 cycles; dp_en stays 0.
  - Transfer happens on the cycle out_ready=1.
- Back-to-back: start held high, out_ready=1, key_valid=1.
  - The second INIT immediately follows the first DONE.
  - out_valid pulses every 12 cycles; in_ready is high only in the DONE cycles.
- Ignored start and key gating:
  - start pulsed at cycle 5 of a sequence → no effect, latency unchanged.
  - start with key_valid=0 in IDLE → in_ready=0 and the block stays in IDLE.
- Reset mid-operation: rst high at cycle 6 (ROUND, round_idx=5) → next cycle IDLE, all outputs at reset values, no out_valid.
- Parameter sweep NR=12 and NR=14:
  - round_idx starts at 12 / 14.
  - out_valid arrives at cycle 14 / 16.
  - Datapath test vectors FIPS-197 C.2 / C.3 decrypt correctly.
